// File: rtl/sprite_frame_ram_flip.sv
// Multi-frame sprite pixel store with read-time mirroring, 2-stage read pipeline,
// out-of-bounds transparency and a self-timed whole-memory fill engine.
module sprite_frame_ram_flip #(
  parameter int unsigned DATA_W    = 5,
  parameter int unsigned SPR_W     = 32,
  parameter int unsigned SPR_H     = 66,
  parameter int unsigned N_FRAMES  = 2,
  parameter int unsigned TRANSP    = 0,
  parameter string       INIT_FILE = "",
  localparam int unsigned DEPTH    = N_FRAMES * SPR_W * SPR_H,
  localparam int unsigned ADDR_W   = $clog2(DEPTH),
  localparam int unsigned FR_W     = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] data_In,
  input  logic              rd_req,
  input  logic [FR_W-1:0]   rd_frame,
  input  logic [9:0]        rd_x,
  input  logic [9:0]        rd_y,
  input  logic              flip_h,
  input  logic              flip_v,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic [DATA_W-1:0] data_Out,
  output logic              rd_valid,
  output logic              busy
);

  localparam int unsigned AW1 = ADDR_W + 1;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   fill_val_q, fill_val_d;
  logic                s1_valid_q, s1_valid_d;
  logic                s1_oob_q, s1_oob_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [DATA_W-1:0]   rd_data_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [9:0]          xe, ye;
  logic [AW1-1:0]      rd_addr_full;
  logic [ADDR_W-1:0]   rd_addr;
  logic                oob;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Stage 1: mirror and linearise; bounds are judged on the raw coordinates.
  always_comb begin
    xe           = flip_h ? 10'(SPR_W - 1) - rd_x : rd_x;
    ye           = flip_v ? 10'(SPR_H - 1) - rd_y : rd_y;
    rd_addr_full = AW1'(rd_frame) * AW1'(SPR_W * SPR_H) + AW1'(ye) * AW1'(SPR_W) + AW1'(xe);
    oob          = (32'(rd_x) >= SPR_W) | (32'(rd_y) >= SPR_H) | (32'(rd_frame) >= N_FRAMES)
                 | (32'(rd_addr_full) >= DEPTH);
    rd_addr      = rd_addr_full[ADDR_W-1:0];
    s1_valid_d   = rd_req;
    s1_oob_d     = oob;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_val_d = fill_val_q;
    mem_we     = 1'b0;
    mem_waddr  = write_address;
    mem_wdata  = data_In;
    unique case (state_q)
      StIdle: begin
        if (fill_start) begin
          state_d    = StFill;
          cnt_d      = '0;
          fill_val_d = fill_value;
        end else begin
          mem_we = we & (32'(write_address) < DEPTH);
        end
      end
      StFill: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = fill_val_q;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    // Memory is never written on a reset edge, so a fill stops exactly where it was.
    mem_we = mem_we & Reset_n;
  end

  always_comb begin
    rd_valid_d = s1_valid_q;
    data_out_d = data_out_q;
    if (s1_valid_q) begin
      data_out_d = s1_oob_q ? DATA_W'(TRANSP) : rd_data_q;
    end
  end

  // Read-first: the array is sampled on the same edge that may write it.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      fill_val_q <= '0;
      s1_valid_q <= 1'b0;
      s1_oob_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_val_q <= fill_val_d;
      s1_valid_q <= s1_valid_d;
      s1_oob_q   <= s1_oob_d;
      rd_valid_q <= rd_valid_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_Out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == StFill);

endmodule

// File: tb/tb_sprite_frame_ram_flip.sv
// Randomised scoreboard bench for sprite_frame_ram_flip against a pixel-array reference model.
module tb_sprite_frame_ram_flip;

    localparam int W      = 32;
    localparam int H      = 66;
    localparam int NF     = 2;
    localparam int DEPTH  = W * H * NF;
    localparam int TRANSP = 0;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        we;
    logic [12:0] write_address;
    logic [4:0]  data_In;
    logic        rd_req;
    logic [0:0]  rd_frame;
    logic [9:0]  rd_x, rd_y;
    logic        flip_h, flip_v;
    logic        fill_start;
    logic [4:0]  fill_value;
    logic [4:0]  data_Out;
    logic        rd_valid;
    logic        busy;

    always #5 Clk = ~Clk;

    sprite_frame_ram_flip dut (
        .Clk(Clk), .Reset_n(Reset_n), .we(we), .write_address(write_address),
        .data_In(data_In), .rd_req(rd_req), .rd_frame(rd_frame), .rd_x(rd_x), .rd_y(rd_y),
        .flip_h(flip_h), .flip_v(flip_v), .fill_start(fill_start), .fill_value(fill_value),
        .data_Out(data_Out), .rd_valid(rd_valid), .busy(busy)
    );

    typedef struct {
        logic [4:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] model [DEPTH];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sprite viewed as an image: a mirrored pixel is the one at the opposite edge.
    function automatic logic [4:0] ref_pixel(input int f, input int x, input int y,
                                             input bit fh, input bit fv);
        int px, py;
        if (x >= W || y >= H || f >= NF) return 5'(TRANSP);
        px = fh ? (W - 1 - x) : x;
        py = fv ? (H - 1 - y) : y;
        return model[(f * H + py) * W + px];
    endfunction

    always @(negedge Clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("rd_valid missing", 32'(rd_valid), 32'(1));
            void'(sb.pop_front());
        end
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected rd_valid", 32'(rd_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check("rd latency", 32'(cyc), 32'(e.cyc));
                check("rd data", 32'(data_Out), 32'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input bit rq, input int f, input int x, input int y, input bit fh,
                         input bit fv, input bit w, input int wa, input logic [4:0] wd);
        rd_req        = rq;
        rd_frame      = 1'(f);
        rd_x          = 10'(x);
        rd_y          = 10'(y);
        flip_h        = fh;
        flip_v        = fv;
        we            = w;
        write_address = 13'(wa);
        data_In       = wd;
        if (rq) sb.push_back('{ref_pixel(f, x, y, fh, fv), cyc + 2});
        if (w && wa < DEPTH) model[wa] = wd;
        step();
        rd_req = 1'b0;
        we     = 1'b0;
    endtask

    task automatic rd(input int f, input int x, input int y, input bit fh, input bit fv);
        issue(1'b1, f, x, y, fh, fv, 1'b0, 0, 5'h0);
    endtask

    task automatic wr(input int wa, input logic [4:0] wd);
        issue(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, wa, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_cycle(input bit force_rd);
        issue(force_rd || ($urandom_range(3) != 0), $urandom_range(1), $urandom_range(35),
              $urandom_range(69), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(DEPTH + 50), 5'($urandom));
    endtask

    initial begin
        int busy_cnt;
        Reset_n = 1'b0; we = 1'b0; write_address = '0; data_In = '0; rd_req = 1'b0;
        rd_frame = '0; rd_x = '0; rd_y = '0; flip_h = 1'b0; flip_v = 1'b0;
        fill_start = 1'b0; fill_value = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 'x;
        idle(2);
        check("reset busy", 32'(busy), 32'(0));
        check("reset rd_valid", 32'(rd_valid), 32'(0));
        check("reset data_Out", 32'(data_Out), 32'(0));
        Reset_n = 1'b1;
        idle(1);

        // Fill races a same-cycle write; the write must lose.
        fill_start = 1'b1; fill_value = 5'h03;
        we = 1'b1; write_address = 13'd5; data_In = 5'h09;
        step();
        fill_start = 1'b0; we = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 5'h03;
        check("busy after fill_start", 32'(busy), 32'(1));
        busy_cnt = busy ? 1 : 0;
        for (int n = 0; n < 6000; n++) begin
            we = 1'($urandom); write_address = 13'($urandom_range(DEPTH - 1));
            data_In = 5'($urandom);
            if (n == 50) begin fill_start = 1'b1; fill_value = 5'h1F; end
            step();
            we = 1'b0; fill_start = 1'b0;
            if (busy) busy_cnt++;
            else break;
        end
        check("fill busy cycles", 32'(busy_cnt), 32'(DEPTH));

        rd(0, 0, 0, 1'b0, 1'b0);
        rd(0, 5, 0, 1'b0, 1'b0);
        rd(1, 31, 65, 1'b0, 1'b0);
        wr(31, 5'h1A);
        rd(0, 0, 0, 1'b1, 1'b0);
        rd(0, 0, 0, 1'b0, 1'b0);
        wr(2111, 5'h07);
        rd(0, 31, 65, 1'b0, 1'b0);
        rd(0, 0, 0, 1'b1, 1'b1);
        // Same-cycle read and write of one pixel returns the old value, then the new one.
        issue(1'b1, 0, 8, 1, 1'b0, 1'b0, 1'b1, 40, 5'h11);
        rd(0, 8, 1, 1'b0, 1'b0);
        wr(DEPTH + 3, 5'h1E);
        rd(1, 0, 0, 1'b0, 1'b1);
        rd(0, 32, 0, 1'b0, 1'b0);
        rd(0, 0, 66, 1'b0, 1'b0);
        rd(1, 1023, 1023, 1'b1, 1'b1);
        idle(3);

        for (int i = 0; i < 800; i++) rand_cycle(1'b0);
        idle(3);

        // Reset with reads in flight: both must vanish.
        rd(1, 3, 3, 1'b0, 1'b0);
        Reset_n = 1'b0; rd_req = 1'b1;
        step();
        Reset_n = 1'b1; rd_req = 1'b0;
        sb.delete();
        check("mid-read reset rd_valid", 32'(rd_valid), 32'(0));
        check("mid-read reset data_Out", 32'(data_Out), 32'(0));
        step();
        check("mid-read reset stage1", 32'(rd_valid), 32'(0));
        idle(2);

        // Reset on fill cycle 100: pixels 0..99 filled, 100 keeps its value.
        wr(100, 5'h1C);
        wr(99, 5'h02);
        fill_start = 1'b1; fill_value = 5'h15;
        step();
        fill_start = 1'b0;
        idle(100);
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        for (int i = 0; i < 100; i++) model[i] = 5'h15;
        check("mid-fill reset busy", 32'(busy), 32'(0));
        rd(0, 0, 0, 1'b0, 1'b0);
        rd(0, 3, 3, 1'b0, 1'b0);
        rd(0, 4, 3, 1'b0, 1'b0);
        rd(0, 5, 3, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) rand_cycle(1'b1);
        idle(4);
        check("scoreboard drained", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
